// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register and fetch stage feeding the decoder through a small instruction queue.
// Ports:
//   clock, reset                      rising-edge clock, asynchronous active-high reset
//   fetchAddress/fetchRequest         word fetch request to the instruction cache, held until fetchGrant
//   fetchGrant, fetchValid, fetchData cache accept strobe and returned instruction word
//   instruction/instructionPC/Valid   head of the instruction queue, consumed on instructionReady
//   branch, unconditionalBranch,      redirect request; taken when unconditional or conditional with zero
//   zeroFlag, branchBasePC, branchOffset   target = branchBasePC + branchOffset*4
//   redirectTaken                     one-cycle pulse the cycle after a redirect
module instruction_fetch #(
  parameter int ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] fetchAddress,
  output logic                  fetchRequest,
  input  logic                  fetchGrant,
  input  logic                  fetchValid,
  input  logic [31:0]           fetchData,
  output logic [31:0]           instruction,
  output logic [ADDR_WIDTH-1:0] instructionPC,
  output logic                  instructionValid,
  input  logic                  instructionReady,
  input  logic                  branch,
  input  logic                  unconditionalBranch,
  input  logic                  zeroFlag,
  input  logic [ADDR_WIDTH-1:0] branchBasePC,
  input  logic [ADDR_WIDTH-1:0] branchOffset,
  output logic                  redirectTaken
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DRAIN} stateType;
  stateType state, nextState;
  logic [ADDR_WIDTH-1:0] pc, pendingPC, target;
  logic [31:0] queueData [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] queuePC [QUEUE_DEPTH];
  logic [PW-1:0] readPtr, writePtr;
  logic [PW:0] count;
  logic taken, granted, enqueue, dequeue;
  // Only FETCH can have no request outstanding, so the queue count alone decides whether a slot is free.
  assign fetchRequest = state == FETCH && count < (PW+1)'(QUEUE_DEPTH);
  assign fetchAddress = pc;
  assign instruction = queueData[readPtr];
  assign instructionPC = queuePC[readPtr];
  assign instructionValid = count != '0;
  assign taken = unconditionalBranch | (branch & zeroFlag);
  assign target = branchBasePC + (branchOffset << 2);
  assign granted = fetchRequest & fetchGrant;
  assign enqueue = state == WAIT && fetchValid && !taken;
  assign dequeue = instructionValid && instructionReady && !taken;
  // A redirect with a request still in flight goes to DRAIN so the stale word is swallowed.
  always_comb
    nextState = state == IDLE  ? FETCH :
                state == FETCH ? (granted ? (taken ? DRAIN : WAIT) : FETCH) :
                state == WAIT  ? (fetchValid ? FETCH : (taken ? DRAIN : WAIT)) :
                                 (fetchValid ? FETCH : DRAIN);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      pendingPC <= '0;
      readPtr <= '0;
      writePtr <= '0;
      count <= '0;
      redirectTaken <= 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        queueData[i] <= '0;
        queuePC[i] <= '0;
      end
    end else begin
      state <= nextState;
      redirectTaken <= taken;
      pc <= taken ? target : granted ? pc + ADDR_WIDTH'(4) : pc;
      if (granted) pendingPC <= pc;
      if (enqueue) begin
        queueData[writePtr] <= fetchData;
        queuePC[writePtr] <= pendingPC;
      end
      readPtr <= taken ? '0 : readPtr + PW'(dequeue);
      writePtr <= taken ? '0 : writePtr + PW'(enqueue);
      count <= taken ? '0 : count + (PW+1)'(enqueue) - (PW+1)'(dequeue);
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed scoreboard bench for instruction_fetch with a one-cycle cache model.
module tb_instruction_fetch;
  logic clock = 1'b0;
  logic reset;
  logic [63:0] fetchAddress;
  logic fetchRequest, fetchGrant, fetchValid;
  logic [31:0] fetchData, instruction;
  logic [63:0] instructionPC;
  logic instructionValid, instructionReady;
  logic branch, unconditionalBranch, zeroFlag;
  logic [63:0] branchBasePC, branchOffset;
  logic redirectTaken;
  int vectors = 0;
  int miscompares = 0;
  int grantCount = 0;
  logic hold = 1'b0;
  logic pend = 1'b0;
  logic [63:0] pendAddr = '0;
  logic [95:0] sb[$];

  instruction_fetch dut (
    .clock(clock), .reset(reset), .fetchAddress(fetchAddress), .fetchRequest(fetchRequest),
    .fetchGrant(fetchGrant), .fetchValid(fetchValid), .fetchData(fetchData),
    .instruction(instruction), .instructionPC(instructionPC), .instructionValid(instructionValid),
    .instructionReady(instructionReady), .branch(branch), .unconditionalBranch(unconditionalBranch),
    .zeroFlag(zeroFlag), .branchBasePC(branchBasePC), .branchOffset(branchOffset),
    .redirectTaken(redirectTaken)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] dataOf(input logic [63:0] a);
    return 32'hC300_0000 ^ a[31:0];
  endfunction

  task automatic expectFetch(input logic [63:0] a);
    sb.push_back({dataOf(a), a});
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic grants(input int n);
    int target;
    target = grantCount + n;
    fetchGrant = 1'b1;
    for (int i = 0; i < 100 && grantCount < target; i++) cycle();
    fetchGrant = 1'b0;
    check("grants_done", 64'(grantCount >= target), 64'd1);
  endtask

  task automatic waitEmpty();
    for (int i = 0; i < 100 && sb.size() != 0; i++) cycle();
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  // Cache model: a grant seen before an edge returns its word the following cycle unless held back.
  initial begin
    fetchValid = 1'b0;
    fetchData = '0;
    forever begin
      @(negedge clock);
      if (reset) pend = 1'b0;
      else if (fetchGrant && fetchRequest) begin
        pend = 1'b1;
        pendAddr = fetchAddress;
      end
      @(posedge clock);
      #2;
      fetchValid = pend && !hold;
      fetchData = fetchValid ? dataOf(pendAddr) : 32'h0;
      if (fetchValid) pend = 1'b0;
    end
  end

  always @(negedge clock)
    if (!reset && fetchGrant && fetchRequest) grantCount++;

  // Monitor: every accepted head entry must be the next expected fetch; a redirect suppresses acceptance.
  always @(negedge clock)
    if (!reset && instructionValid && instructionReady && !(unconditionalBranch || (branch && zeroFlag))) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_instr: got pc=%h data=%h expected none", instructionPC, instruction);
      end else begin
        logic [95:0] e;
        e = sb.pop_front();
        if ({instruction, instructionPC} !== e) begin
          miscompares++;
          $display("FAIL instr: got pc=%h data=%h expected pc=%h data=%h",
                   instructionPC, instruction, e[63:0], e[95:64]);
        end
      end
    end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    fetchGrant = 1'b0;
    instructionReady = 1'b0;
    branch = 1'b0;
    unconditionalBranch = 1'b0;
    zeroFlag = 1'b0;
    branchBasePC = '0;
    branchOffset = '0;
    #3;
    check("rst_fetchRequest", 64'(fetchRequest), 64'd0);
    check("rst_fetchAddress", fetchAddress, 64'h0);
    check("rst_instructionValid", 64'(instructionValid), 64'd0);
    check("rst_redirectTaken", 64'(redirectTaken), 64'd0);
    check("rst_instruction", 64'(instruction), 64'h0);
    check("rst_instructionPC", instructionPC, 64'h0);
    cycle();
    cycle();
    reset = 1'b0;
    // Streaming with ready high: in-order fetch from address 0.
    instructionReady = 1'b1;
    for (int a = 0; a < 32; a += 4) expectFetch(64'(a));
    grants(8);
    waitEmpty();
    // Backpressure: queue fills to depth 2 and fetching stops.
    instructionReady = 1'b0;
    fetchGrant = 1'b1;
    repeat (5) cycle();
    check("bp_head_pc_early", instructionPC, 64'h20);
    repeat (5) cycle();
    check("bp_fetchRequest", 64'(fetchRequest), 64'd0);
    check("bp_valid", 64'(instructionValid), 64'd1);
    check("bp_head_pc", instructionPC, 64'h20);
    check("bp_head_data", 64'(instruction), 64'(dataOf(64'h20)));
    expectFetch(64'h20);
    expectFetch(64'h24);
    fetchGrant = 1'b0;
    instructionReady = 1'b1;
    waitEmpty();
    check("bp_next_addr", fetchAddress, 64'h28);
    check("bp_next_req", 64'(fetchRequest), 64'd1);
    check("bp_empty", 64'(instructionValid), 64'd0);
    // Redirect in WAIT with the response still outstanding: drain, then fetch 0x100 - 8.
    instructionReady = 1'b0;
    hold = 1'b1;
    grants(1);
    branch = 1'b1;
    zeroFlag = 1'b1;
    branchBasePC = 64'h100;
    branchOffset = 64'hFFFF_FFFF_FFFF_FFFE;
    cycle();
    branch = 1'b0;
    zeroFlag = 1'b0;
    check("wait_redir_pulse", 64'(redirectTaken), 64'd1);
    check("wait_redir_drain_req", 64'(fetchRequest), 64'd0);
    cycle();
    check("wait_redir_pulse_once", 64'(redirectTaken), 64'd0);
    check("wait_redir_drain_req2", 64'(fetchRequest), 64'd0);
    hold = 1'b0;
    cycle();
    check("wait_redir_addr", fetchAddress, 64'hF8);
    check("wait_redir_req", 64'(fetchRequest), 64'd1);
    check("wait_redir_valid", 64'(instructionValid), 64'd0);
    instructionReady = 1'b1;
    expectFetch(64'hF8);
    grants(1);
    waitEmpty();
    // Redirect in WAIT coinciding with the response: word discarded, target fetched directly.
    grants(1);
    branch = 1'b1;
    zeroFlag = 1'b1;
    branchBasePC = 64'h200;
    branchOffset = 64'h4;
    cycle();
    branch = 1'b0;
    zeroFlag = 1'b0;
    check("waitv_redir_addr", fetchAddress, 64'h210);
    check("waitv_redir_req", 64'(fetchRequest), 64'd1);
    check("waitv_redir_pulse", 64'(redirectTaken), 64'd1);
    check("waitv_redir_valid", 64'(instructionValid), 64'd0);
    // Conditional branch with zeroFlag low: no redirect.
    expectFetch(64'h210);
    grants(1);
    branch = 1'b1;
    branchBasePC = 64'h100;
    branchOffset = 64'hFFFF_FFFF_FFFF_FFFE;
    cycle();
    branch = 1'b0;
    check("nt_pulse", 64'(redirectTaken), 64'd0);
    check("nt_addr", fetchAddress, 64'h214);
    waitEmpty();
    // Unconditional redirect in the grant cycle, target wraps to 0x4.
    hold = 1'b1;
    fetchGrant = 1'b1;
    unconditionalBranch = 1'b1;
    branchBasePC = 64'hFFFF_FFFF_FFFF_FFFC;
    branchOffset = 64'h2;
    cycle();
    fetchGrant = 1'b0;
    unconditionalBranch = 1'b0;
    check("grant_redir_pulse", 64'(redirectTaken), 64'd1);
    check("grant_redir_drain_req", 64'(fetchRequest), 64'd0);
    cycle();
    check("grant_redir_drain_req2", 64'(fetchRequest), 64'd0);
    hold = 1'b0;
    cycle();
    check("grant_redir_addr", fetchAddress, 64'h4);
    check("grant_redir_req", 64'(fetchRequest), 64'd1);
    check("grant_redir_valid", 64'(instructionValid), 64'd0);
    expectFetch(64'h4);
    grants(1);
    waitEmpty();
    // Redirect coinciding with ready, an enqueue and a reserved-full queue.
    instructionReady = 1'b0;
    grants(1);
    cycle();
    hold = 1'b1;
    grants(1);
    hold = 1'b0;
    instructionReady = 1'b1;
    unconditionalBranch = 1'b1;
    branchBasePC = 64'h300;
    branchOffset = 64'h0;
    cycle();
    unconditionalBranch = 1'b0;
    check("flush_valid", 64'(instructionValid), 64'd0);
    check("flush_addr", fetchAddress, 64'h300);
    check("flush_req", 64'(fetchRequest), 64'd1);
    check("flush_pulse", 64'(redirectTaken), 64'd1);
    expectFetch(64'h300);
    grants(1);
    waitEmpty();
    // Reset while waiting with one entry queued.
    instructionReady = 1'b0;
    grants(1);
    cycle();
    hold = 1'b1;
    grants(1);
    check("pre_reset_valid", 64'(instructionValid), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 64'(instructionValid), 64'd0);
    check("mid_rst_req", 64'(fetchRequest), 64'd0);
    check("mid_rst_addr", fetchAddress, 64'h0);
    check("mid_rst_instr", 64'(instruction), 64'h0);
    check("mid_rst_pc", instructionPC, 64'h0);
    check("mid_rst_pulse", 64'(redirectTaken), 64'd0);
    cycle();
    hold = 1'b0;
    cycle();
    reset = 1'b0;
    instructionReady = 1'b1;
    expectFetch(64'h0);
    expectFetch(64'h4);
    grants(2);
    waitEmpty();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
